mod_dm: RTL and testbench
=========================

Name: mod_dm

Overview:
- Word-organised data memory for the MIPS pipeline MEM stage.
- Combinational read of the addressed 32-bit word.
- Synchronous, byte-enabled write on the rising clock edge.
- pc_now is carried only for the optional write-trace feature and has no functional effect.

Parameters:
- ADDR_WIDTH, 10, number of word-index bits; depth = 2^ADDR_WIDTH words (default 1024 words = 4 KiB).

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted); clears the entire array.
- address  input  32  byte address; word index = address[ADDR_WIDTH+1:2].
- dm_data_in  input  32  store data, already lane-aligned by the store-shift logic upstream.
- pc_now  input  32  PC of the instruction issuing the access; used for tracing only.
- dm_write  input  1  write strobe, active-high.
- BE  input  4  byte-lane enables; BE[i] enables bits [8i+7:8i].
- dm_data_out  output  32  addressed word, combinational.

Behaviour:
- Storage: 2^ADDR_WIDTH x 32-bit registers.
- Indexing:
  - address[1:0] is ignored.
  - address[31:ADDR_WIDTH+2] is ignored, so addresses wrap modulo 4*2^ADDR_WIDTH bytes.
- Reset:
  - While reset=0, every word is cleared to 32'h0 immediately, without waiting for a clock edge.
  - dm_data_out therefore reads 32'h0 during reset.
  - Writes are blocked while reset=0, including a write on the edge where reset is asserted.
  - Reset release has no extra latency: the first rising edge with reset=1 may write.
- Read:
  - dm_data_out = mem[index], purely combinational, zero-cycle latency.
  - Not gated by dm_write or BE.
- Write:
  - On a rising clk edge with reset=1 and dm_write=1, for each i with BE[i]=1: mem[index][8i+7:8i] <= dm_data_in[8i+7:8i].
  - Lanes with BE[i]=0 keep their previous contents.
- Degenerate write cases:
  - BE=4'b0000 with dm_write=1 leaves the memory unchanged.
  - dm_write=0 leaves the memory unchanged regardless of BE.
- Read-during-write: dm_data_out shows the old word until the edge, then the merged word in the same cycle after the edge.
- Successive writes to the same word compose byte-wise (see Test Plan #2).
- No handshake, no stall, and no error output.
- There is no X-propagation requirement beyond standard RTL semantics.

Optional Feature:
- Macro: DM_WRITE_TRACE_EN.
- Defined: on every effective write (dm_write=1, reset=1, rising edge), the block prints one simulation line:
  - format "@<pc_now hex8>: *<byte address with [1:0]=00, hex8> <= <full merged word hex8>";
  - the merged word is the value after the byte merge;
  - one line per edge for as long as dm_write stays high.
- Not defined: no trace code is compiled; behaviour is otherwise identical.
- In both cases the pc_now port remains present.

Test Plan:
1. Hold reset=0 with clk toggling and dm_write=1 -> every read returns 32'h0 and no write lands. Release reset; read address 0 -> 32'h00000000.
2. Same-word byte merge, address=0, dm_data_in=32'h12345678:
   - dm_write=1, BE=4'b0011, one edge -> dm_data_out=32'h00005678.
   - Then BE=4'b1000, one edge -> 32'h12005678.
   - Then dm_write=0 with further edges -> value stays 32'h12005678.
3. Full-word write, dm_data_in=32'hDEADBEEF, BE=4'b1111:
   - To address 32'h00000008 -> reading address 32'h0000000B also returns 32'hDEADBEEF (low bits ignored).
   - Address 32'h00000004 still returns 0.
4. Wrap-around: write 32'hA5A5A5A5 with BE=4'b1111 to address 32'h00001004 -> reading 32'h00000004 returns 32'hA5A5A5A5 (ADDR_WIDTH=10).
5. dm_write=1 with BE=4'b0000 over a word holding 32'h12005678 -> unchanged.
6. Reset mid-operation:
   - Assert reset=0 asynchronously between edges after test 2 -> dm_data_out drops to 0 before the next edge.
   - The word stays 0 after reset is released.
   - With DM_WRITE_TRACE_EN defined, test 2 prints "@00000000: *00000000 <= 00005678" then "... <= 12005678".

Source files
------------

// File: rtl/mod_dm.sv
// Word-organised data memory for the MEM stage: combinational read, byte-enabled synchronous write.
// Optional write trace under `DM_WRITE_TRACE_EN` (simulation print per effective write).
module mod_dm #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] dm_data_in,
    input  logic [31:0] pc_now,
    input  logic        dm_write,
    input  logic [3:0]  BE,
    output logic [31:0] dm_data_out
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           wdata_d;

    assign idx         = address[ADDR_WIDTH+1:2];
    assign dm_data_out = mem_q[idx];

    // Merge enabled lanes of the store data over the currently stored word.
    always_comb begin
        wdata_d = mem_q[idx];
        for (int i = 0; i < 4; i++) begin
            if (BE[i]) wdata_d[8*i +: 8] = dm_data_in[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < DEPTH; w++) mem_q[w] <= 32'h0;
        end else if (dm_write) begin
            mem_q[idx] <= wdata_d;
        end
    end

`ifdef DM_WRITE_TRACE_EN
    always @(posedge clk) begin
        if (reset && dm_write)
            $display("@%h: *%h <= %h", pc_now, {address[31:2], 2'b00}, wdata_d);
    end
    logic unused_bits;
    assign unused_bits = ^{address[1:0]};
`else
    // Address bits outside the word index and the PC only matter for tracing.
    logic unused_bits;
    assign unused_bits = ^{pc_now, address[1:0]};
`endif

    if (ADDR_WIDTH < 30) begin : g_hi_unused
        logic unused_hi;
        assign unused_hi = ^address[31:ADDR_WIDTH+2];
    end
endmodule

// File: tb/tb_mod_dm.sv
// Directed self-checking bench for mod_dm with hand-computed expected values.
module tb_mod_dm;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] dm_data_in;
    logic [31:0] pc_now;
    logic        dm_write;
    logic [3:0]  BE;
    logic [31:0] dm_data_out;

    int errs = 0;
    int checks = 0;

    mod_dm #(.ADDR_WIDTH(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .dm_data_in (dm_data_in),
        .pc_now     (pc_now),
        .dm_write   (dm_write),
        .BE         (BE),
        .dm_data_out(dm_data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(tag, dm_data_out, exp);
    endtask

    initial begin
        reset = 1'b0; address = 32'h0; dm_data_in = 32'hFFFFFFFF;
        pc_now = 32'h0; dm_write = 1'b1; BE = 4'hF;

        // Writes attempted while reset is held must not land.
        repeat (4) tick();
        rd("rst_rd0", 32'h0, 32'h0);
        address = 32'h8;
        tick();
        rd("rst_rd8", 32'h8, 32'h0);

        dm_write = 1'b0;
        reset = 1'b1;
        rd("rel_rd0", 32'h0, 32'h0);

        // Byte merge into word 0, including read-during-write ordering.
        address = 32'h0; dm_data_in = 32'h12345678; BE = 4'b0011; dm_write = 1'b1;
        #1 chk("rdw_old", dm_data_out, 32'h0);
        tick();
        chk("merge_lo", dm_data_out, 32'h00005678);
        BE = 4'b1000;
        tick();
        chk("merge_hi", dm_data_out, 32'h12005678);
        dm_write = 1'b0; BE = 4'hF; dm_data_in = 32'hFFFFFFFF;
        repeat (2) tick();
        chk("nowrite_hold", dm_data_out, 32'h12005678);

        dm_write = 1'b1; BE = 4'b0000;
        tick();
        chk("be0_hold", dm_data_out, 32'h12005678);

        // Full-word write; low address bits ignored.
        address = 32'h8; dm_data_in = 32'hDEADBEEF; BE = 4'hF;
        tick();
        dm_write = 1'b0;
        rd("full_rdB", 32'hB, 32'hDEADBEEF);
        rd("neigh_rd4", 32'h4, 32'h0);

        // Wrap-around modulo 4 KiB.
        address = 32'h1004; dm_data_in = 32'hA5A5A5A5; dm_write = 1'b1;
        tick();
        dm_write = 1'b0;
        rd("wrap_rd4", 32'h4, 32'hA5A5A5A5);
        rd("wrap_rd8", 32'h8, 32'hDEADBEEF);
        rd("wrap_rd0", 32'h0, 32'h12005678);

        // Asynchronous reset mid-cycle clears immediately.
        #2 reset = 1'b0;
        #1 chk("async_rd0", dm_data_out, 32'h0);
        rd("async_rd8", 32'h8, 32'h0);
        dm_write = 1'b1; dm_data_in = 32'h55555555;
        tick();
        chk("rst_wr_blk", dm_data_out, 32'h0);
        dm_write = 1'b0;
        reset = 1'b1;
        rd("post_rel0", 32'h0, 32'h0);
        rd("post_rel4", 32'h4, 32'h0);

        // First edge after release may write; partial lane write.
        address = 32'h10; dm_data_in = 32'h11223344; BE = 4'b0100; dm_write = 1'b1;
        tick();
        chk("first_wr", dm_data_out, 32'h00220000);
        BE = 4'b1001; dm_data_in = 32'hAABBCCDD;
        tick();
        chk("lanes_mix", dm_data_out, 32'hAA2200DD);
        dm_write = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
